lsu_mc: RTL

LSU_MC -- requirements
Module: lsu_mc

---
 rtl/lsu_mc.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_mc.sv
// lsu_mc -- multi-cycle load/store unit with a word-addressed DMEM and a
// small memory-mapped IO page (LEDR, LEDG, HEX, SW, BTN).
//
// Ports
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_req, i_we, i_funct3,        request; sampled only in IDLE
//   i_addr, i_st_data
//   o_ack                         one-cycle completion pulse (state RESP)
//   o_err, o_ld_data              response, valid with o_ack, 0 otherwise
//   o_busy                        FSM not in IDLE
//   i_io_sw, i_io_btn             read-only IO inputs
//   o_io_ledr, o_io_ledg, o_io_hex  writable IO registers
//
// Timing: IO, unmapped and faulting requests respond in the cycle right
// after acceptance. DMEM requests spend MEM_LAT-1 cycles in MEM (minimum
// one), so o_ack appears MEM_LAT cycles after acceptance.

// One byte lane of a byte-enabled register update.
module lsu_mc_lane (
  input  logic [7:0] old_b,
  input  logic [7:0] new_b,
  input  logic       be,
  output logic [7:0] out_b
);
  assign out_b = be ? new_b : old_b;
endmodule

module lsu_mc #(
  parameter int          DMEM_ADDR_W = 11,
  parameter int          MEM_LAT     = 2,
  parameter logic [31:0] IO_BASE     = 32'h0000_7000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_st_data,
  output logic        o_ack,
  output logic        o_err,
  output logic        o_busy,
  output logic [31:0] o_ld_data,
  input  logic [31:0] i_io_sw,
  input  logic [3:0]  i_io_btn,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [31:0] o_io_hex
);
  localparam int NUM_LANES = 4;
  localparam int CNT_W     = 3;

  typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  // IO word offsets (addr[7:2])
  localparam logic [5:0] OFF_LEDR = 6'h00;
  localparam logic [5:0] OFF_LEDG = 6'h04;
  localparam logic [5:0] OFF_HEX  = 6'h08;
  localparam logic [5:0] OFF_SW   = 6'h10;
  localparam logic [5:0] OFF_BTN  = 6'h14;

  function automatic logic [NUM_LANES-1:0] be_of(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   be_of = 4'b0001 << a;
      2'b01:   be_of = 4'b0011 << {a[1], 1'b0};
      default: be_of = 4'b1111;
    endcase
  endfunction

  // Store data replicated across lanes; byte enables pick the live copy.
  function automatic logic [31:0] wdata_of(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   wdata_of = {4{d[7:0]}};
      2'b01:   wdata_of = {2{d[15:0]}};
      default: wdata_of = d;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> {a, 3'b000};
    case (f3)
      3'b000:  load_ext = {{24{sh[7]}}, sh[7:0]};
      3'b100:  load_ext = {24'h0, sh[7:0]};
      3'b001:  load_ext = {{16{sh[15]}}, sh[15:0]};
      3'b101:  load_ext = {16'h0, sh[15:0]};
      default: load_ext = sh;
    endcase
  endfunction

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  req_t             req_q;
  logic [31:0]      mem [2**DMEM_ADDR_W];

  // ---------------- request decode (combinational, used at acceptance)
  logic                 accept, f3_ok, misal, in_dmem, in_io;
  logic                 io_hit, io_ro, io_wen, path_dmem, err_in;
  logic [5:0]           io_sel;
  logic [NUM_LANES-1:0] be_in;
  logic [31:0]          wdata_in, io_rd, io_wr, io_ld;

  assign accept = (state == IDLE) && i_req;

  always_comb begin
    f3_ok = 1'b0;
    case (i_funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = !i_we;   // unsigned forms are load-only
      default:                f3_ok = 1'b0;
    endcase
  end

  assign misal   = (i_funct3[1:0] == 2'b01 && i_addr[0]) ||
                   (i_funct3[1:0] == 2'b10 && i_addr[1:0] != 2'b00);
  assign in_dmem = (i_addr[31:DMEM_ADDR_W+2] == '0);
  assign in_io   = (i_addr[31:8] == IO_BASE[31:8]);
  assign io_sel  = i_addr[7:2];
  assign be_in   = be_of(i_funct3, i_addr[1:0]);
  assign wdata_in = wdata_of(i_funct3, i_st_data);

  always_comb begin
    io_rd  = '0;
    io_hit = 1'b1;
    io_ro  = 1'b0;
    case (io_sel)
      OFF_LEDR: io_rd = o_io_ledr;
      OFF_LEDG: io_rd = o_io_ledg;
      OFF_HEX:  io_rd = o_io_hex;
      OFF_SW:   begin io_rd = i_io_sw;           io_ro = 1'b1; end
      OFF_BTN:  begin io_rd = {28'h0, i_io_btn}; io_ro = 1'b1; end
      default:  io_hit = 1'b0;
    endcase
  end

  // DMEM takes priority should the IO page ever overlap it.
  assign path_dmem = f3_ok && !misal && in_dmem;
  assign err_in    = !f3_ok || misal ||
                     (!in_dmem && (!in_io || !io_hit || (i_we && io_ro)));
  assign io_wen    = accept && !err_in && !in_dmem && i_we;
  assign io_ld     = (err_in || i_we) ? 32'h0 : load_ext(i_funct3, i_addr[1:0], io_rd);

  // Merge new bytes into whichever writable register is selected.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lsu_mc_lane u_lane (
      .old_b (io_rd[8*g +: 8]),
      .new_b (wdata_in[8*g +: 8]),
      .be    (be_in[g]),
      .out_b (io_wr[8*g +: 8])
    );
  end

  // ---------------- FSM
  logic mem_done;
  // Exit on the edge where the counter reaches 0; a counter loaded with 0
  // (MEM_LAT=1) still leaves after its single MEM cycle.
  assign mem_done = (state == MEM) && (cnt <= CNT_W'(1));
  assign o_busy   = (state != IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_req) state_nxt = path_dmem ? MEM : RESP;
      MEM:     if (mem_done) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)                          cnt <= '0;
    else if (accept && path_dmem)       cnt <= CNT_W'(MEM_LAT - 1);
    else if (state == MEM && cnt != '0) cnt <= cnt - 1'b1;
  end

  // ---------------- registered request and response
  logic [DMEM_ADDR_W-1:0] idx_q;
  logic [NUM_LANES-1:0]   be_q;
  logic [31:0]            wdata_q;
  logic                   unused_addr_hi;

  assign idx_q          = req_q.addr[DMEM_ADDR_W+1:2];
  assign be_q           = be_of(req_q.funct3, req_q.addr[1:0]);
  assign wdata_q        = wdata_of(req_q.funct3, req_q.data);
  assign unused_addr_hi = ^req_q.addr[31:DMEM_ADDR_W+2];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      req_q     <= '0;
      o_ack     <= 1'b0;
      o_err     <= 1'b0;
      o_ld_data <= '0;
      o_io_ledr <= '0;
      o_io_ledg <= '0;
      o_io_hex  <= '0;
    end else begin
      o_ack     <= 1'b0;
      o_err     <= 1'b0;
      o_ld_data <= '0;
      if (accept) begin
        req_q <= '{we: i_we, funct3: i_funct3, addr: i_addr, data: i_st_data};
        if (!path_dmem) begin
          o_ack     <= 1'b1;
          o_err     <= err_in;
          o_ld_data <= io_ld;
        end
        if (io_wen) begin
          case (io_sel)
            OFF_LEDR: o_io_ledr <= io_wr;
            OFF_LEDG: o_io_ledg <= io_wr;
            OFF_HEX:  o_io_hex  <= io_wr;
            default:  ;
          endcase
        end
      end
      if (mem_done) begin
        o_ack     <= 1'b1;
        o_ld_data <= req_q.we ? 32'h0 : load_ext(req_q.funct3, req_q.addr[1:0], mem[idx_q]);
      end
    end
  end

  // DMEM has no reset; a reset during MEM suppresses the pending write.
  always_ff @(posedge i_clk) begin
    if (!i_rst && mem_done && req_q.we) begin
      for (int b = 0; b < NUM_LANES; b++)
        if (be_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
    end
  end

endmodule
